// File: rtl/ntt_pkg.sv
// Shared types and defaults for the NTT frame scheduler slice.
package ntt_pkg;

    localparam int BPF_DEF      = 32;
    localparam int LAT_DEF      = 64;
    localparam int INFLIGHT_DEF = 4;
    localparam int TAG_W_DEF    = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } sched_state_e;

    // One delay-line slot: what entered the core on a given cycle.
    typedef struct packed {
        logic en;
        logic first;
        logic last;
    } pipe_slot_t;

    function automatic int beat_idx_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/ntt_tag_fifo.sv
// Small synchronous FIFO holding the tags of admitted frames; head is a raw
// memory read (no output register) so it is valid in the same cycle.
module ntt_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop & (count_q != '0);
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ntt_frame_scheduler.sv
// Admits credit-gated frames into the fixed-latency NTT core and regenerates
// frame-aligned valid/first/last/tag markers on the core output.
module ntt_frame_scheduler
    import ntt_pkg::*;
#(
    parameter int BEATS_PER_FRAME = BPF_DEF,
    parameter int PIPE_LATENCY    = LAT_DEF,
    parameter int MAX_INFLIGHT    = INFLIGHT_DEF,
    parameter int TAG_WIDTH       = TAG_W_DEF,
    localparam int IW = beat_idx_w(BEATS_PER_FRAME),
    localparam int CW = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [TAG_WIDTH-1:0] s_tag,
    output logic                 core_in_en,
    output logic                 core_in_first,
    output logic [IW-1:0]        core_beat_idx,
    output logic                 m_valid,
    output logic                 m_first,
    output logic                 m_last,
    output logic [TAG_WIDTH-1:0] m_tag,
    input  logic                 credit_return,
    output logic [CW-1:0]        credits,
    output logic                 busy,
    output logic                 err_credit
);

    localparam logic [0:0]    IDLE     = ST_IDLE;
    localparam logic [0:0]    STREAM   = ST_STREAM;
    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS_PER_FRAME - 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(MAX_INFLIGHT);

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] beat_cnt_q, beat_cnt_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          err_q, err_d;

    pipe_slot_t [PIPE_LATENCY:1] vld_pipe_q, vld_pipe_d;
    pipe_slot_t                  slot_in;

    logic                 admit, accept_last, ret_ok, pipe_any;
    logic                 fifo_push, fifo_pop;
    logic [CW-1:0]        fifo_cnt;
    logic [TAG_WIDTH-1:0] fifo_head;

    always_comb begin
        s_ready       = (state_q == STREAM) | (credits_q != '0);
        core_in_en    = s_valid & s_ready;
        admit         = core_in_en & (state_q == IDLE);
        core_in_first = admit;
        core_beat_idx = beat_cnt_q;
        accept_last   = core_in_en & (beat_cnt_q == LAST_IDX);

        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (accept_last) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
        end else if (core_in_en) begin
            state_d    = STREAM;
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        // A return while already full is dropped and flagged, even if an
        // admission happens in the same cycle.
        ret_ok    = credit_return & (credits_q != CRED_MAX);
        credits_d = credits_q + CW'(ret_ok) - CW'(admit);
        err_d     = err_q | (credit_return & (credits_q == CRED_MAX));

        slot_in.en    = core_in_en;
        slot_in.first = admit;
        slot_in.last  = accept_last;

        vld_pipe_d    = vld_pipe_q;
        vld_pipe_d[1] = slot_in;
        for (int i = 2; i <= PIPE_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];

        pipe_any = 1'b0;
        for (int i = 1; i <= PIPE_LATENCY; i++) pipe_any = pipe_any | vld_pipe_q[i].en;

        m_valid = vld_pipe_q[PIPE_LATENCY].en;
        m_first = vld_pipe_q[PIPE_LATENCY].first;
        m_last  = vld_pipe_q[PIPE_LATENCY].last;
        m_tag   = fifo_head;

        fifo_pop  = m_valid & m_last;
        fifo_push = admit & ((fifo_cnt != CRED_MAX) | fifo_pop);

        busy = (state_q == STREAM) | pipe_any;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            credits_q  <= CRED_MAX;
            err_q      <= 1'b0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            credits_q  <= credits_d;
            err_q      <= err_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign credits    = credits_q;
    assign err_credit = err_q;

    ntt_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (TAG_WIDTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (s_tag),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .count (fifo_cnt)
    );

endmodule

// File: tb/tb_ntt_frame_scheduler.sv
// Scenario bench for ntt_frame_scheduler against a timestamped beat model.
module tb_ntt_frame_scheduler;

    localparam int BPF  = 32;
    localparam int LAT  = 64;
    localparam int MAXC = 4;

    logic       clk = 1'b0;
    logic       rst, s_valid, s_ready, core_in_en, core_in_first;
    logic [3:0] s_tag, m_tag;
    logic [4:0] core_beat_idx;
    logic       m_valid, m_first, m_last, credit_return, busy, err_credit;
    logic [2:0] credits;

    ntt_frame_scheduler dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_tag(s_tag),
        .core_in_en(core_in_en), .core_in_first(core_in_first), .core_beat_idx(core_beat_idx),
        .m_valid(m_valid), .m_first(m_first), .m_last(m_last), .m_tag(m_tag),
        .credit_return(credit_return), .credits(credits), .busy(busy), .err_credit(err_credit)
    );

    always #5 clk = ~clk;

    // Each accepted beat is predicted to show at (accept cycle + LAT).
    typedef struct { int t; bit first; bit last; } beat_t;
    beat_t exp_q[$];
    int    tag_q[$];
    int    m_cred, m_bc, m_done, cyc;
    bit    m_err, last_acc;
    int    n_cmp, n_bad;
    int    obs_cyc[$];
    bit    obs_first[$], obs_last[$];

    task automatic model_reset();
        exp_q.delete(); tag_q.delete();
        m_cred = MAXC; m_bc = 0; m_done = 0; m_err = 0;
    endtask

    task automatic step(input bit v, input bit [3:0] tag, input bit ret, input bit r);
        bit e_ready, e_en, e_mv, e_first, e_last, e_busy;
        int adm;
        beat_t b;
        s_valid = v; s_tag = tag; credit_return = ret; rst = r;
        #1;
        e_ready = (m_bc != 0) || (m_cred > 0);
        e_en    = v && e_ready;
        e_mv    = (exp_q.size() > 0) && (exp_q[0].t == cyc);
        e_first = e_mv && exp_q[0].first;
        e_last  = e_mv && exp_q[0].last;
        e_busy  = (m_bc != 0) || (exp_q.size() > 0);
        n_cmp += 7;
        if (s_ready !== e_ready) begin n_bad++; $display("FAIL s_ready cyc %0d: got %b want %b", cyc, s_ready, e_ready); end
        if (core_in_en !== e_en) begin n_bad++; $display("FAIL core_in_en cyc %0d: got %b want %b", cyc, core_in_en, e_en); end
        if (m_valid !== e_mv) begin n_bad++; $display("FAIL m_valid cyc %0d: got %b want %b", cyc, m_valid, e_mv); end
        if (m_first !== e_first) begin n_bad++; $display("FAIL m_first cyc %0d: got %b want %b", cyc, m_first, e_first); end
        if (m_last !== e_last) begin n_bad++; $display("FAIL m_last cyc %0d: got %b want %b", cyc, m_last, e_last); end
        if (credits !== 3'(m_cred)) begin n_bad++; $display("FAIL credits cyc %0d: got %0d want %0d", cyc, credits, m_cred); end
        if (busy !== e_busy || err_credit !== m_err) begin
            n_bad++; $display("FAIL busy/err cyc %0d: got %b/%b want %b/%b", cyc, busy, err_credit, e_busy, m_err);
        end
        if (e_en) begin
            n_cmp++;
            if (core_in_first !== (m_bc == 0) || core_beat_idx !== 5'(m_bc)) begin
                n_bad++; $display("FAIL core_beat cyc %0d: got first %b idx %0d want first %b idx %0d",
                                  cyc, core_in_first, core_beat_idx, m_bc == 0, m_bc);
            end
        end
        if (e_mv && tag_q.size() > 0) begin
            n_cmp++;
            if (m_tag !== 4'(tag_q[0])) begin n_bad++; $display("FAIL m_tag cyc %0d: got %0d want %0d", cyc, m_tag, tag_q[0]); end
        end
        if (m_valid === 1'b1) begin obs_cyc.push_back(cyc); obs_first.push_back(m_first); obs_last.push_back(m_last); end
        @(posedge clk);
        last_acc = 0;
        if (r) model_reset();
        else begin
            if (e_mv) begin
                if (exp_q[0].last) begin void'(tag_q.pop_front()); m_done++; end
                void'(exp_q.pop_front());
            end
            adm = (e_en && m_bc == 0) ? 1 : 0;
            if (e_en) begin
                if (m_bc == 0) tag_q.push_back(int'(tag));
                b.t = cyc + LAT; b.first = (m_bc == 0); b.last = (m_bc == BPF - 1);
                exp_q.push_back(b);
                m_bc = (m_bc + 1) % BPF;
                last_acc = 1;
            end
            if (ret && m_cred == MAXC) m_err = 1;
            m_cred = m_cred + ((ret && m_cred != MAXC) ? 1 : 0) - adm;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 4'd0, 0, 0);
    endtask

    task automatic ret_credits(input int n);
        repeat (n) begin if (m_done > 0) m_done--; step(0, 4'd0, 1, 0); end
    endtask

    task automatic send_frame(input bit [3:0] tag, input int bub_at, input int bub_len);
        int sent = 0, guard = 0;
        bit bub = 0;
        while (sent < BPF && guard < 400) begin
            if (sent == bub_at && !bub) begin repeat (bub_len) step(0, tag, 0, 0); bub = 1; end
            step(1, tag, 0, 0);
            if (last_acc) sent++;
            guard++;
        end
        n_cmp++;
        if (sent != BPF) begin n_bad++; $display("FAIL send_frame tag %0d: got %0d beats want %0d", tag, sent, BPF); end
    endtask

    task automatic clear_obs();
        obs_cyc.delete(); obs_first.delete(); obs_last.delete();
    endtask

    task automatic test_reset();
        rst = 1; s_valid = 0; s_tag = 0; credit_return = 0;
        @(negedge clk); @(negedge clk);
        rst = 0; model_reset(); cyc = 0;
        n_cmp += 4;
        if (s_ready !== 1'b1 || credits !== 3'd4) begin n_bad++; $display("FAIL reset_ready_cred: got %b/%0d want 1/4", s_ready, credits); end
        if (m_valid !== 0 || m_first !== 0 || m_last !== 0) begin n_bad++; $display("FAIL reset_mflags: got %b%b%b want 000", m_valid, m_first, m_last); end
        if (busy !== 0 || err_credit !== 0) begin n_bad++; $display("FAIL reset_busy_err: got %b/%b want 0/0", busy, err_credit); end
        if (m_tag !== 4'd0) begin n_bad++; $display("FAIL reset_mtag: got %0d want 0", m_tag); end
    endtask

    task automatic test_single();
        int t0 = cyc;
        clear_obs();
        send_frame(4'd5, -1, 0);
        idle(70);
        n_cmp += 3;
        if (obs_cyc.size() != 32) begin n_bad++; $display("FAIL single_count: got %0d want 32", obs_cyc.size()); end
        else begin
            if (obs_cyc[0] != t0 + 64 || !obs_first[0]) begin n_bad++; $display("FAIL single_first: got cyc %0d want %0d", obs_cyc[0], t0 + 64); end
            if (obs_cyc[31] != t0 + 95 || !obs_last[31]) begin n_bad++; $display("FAIL single_last: got cyc %0d want %0d", obs_cyc[31], t0 + 95); end
        end
        ret_credits(1);
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_frame(4'd1, -1, 0); send_frame(4'd2, -1, 0); send_frame(4'd3, -1, 0);
        n_cmp += 2;
        if (credits !== 3'd1) begin n_bad++; $display("FAIL b2b_credits: got %0d want 1", credits); end
        idle(100);
        if (obs_cyc.size() != 96 || obs_cyc[95] - obs_cyc[0] != 95) begin
            n_bad++; $display("FAIL b2b_run: got %0d beats want 96 contiguous", obs_cyc.size());
        end
        ret_credits(3);
    endtask

    task automatic test_credit_exhaust();
        for (int f = 0; f < 4; f++) send_frame(4'(6 + f), -1, 0);
        repeat (100) step(1, 4'd0, 0, 0);
        n_cmp += 2;
        if (s_ready !== 1'b0 || credits !== 3'd0) begin n_bad++; $display("FAIL exhaust_stall: got ready %b cred %0d want 0/0", s_ready, credits); end
        ret_credits(1);
        if (s_ready !== 1'b1) begin n_bad++; $display("FAIL exhaust_reenable: got %b want 1", s_ready); end
    endtask

    task automatic test_simul();
        if (m_done > 0) m_done--;
        step(1, 4'd10, 1, 0);
        n_cmp += 3;
        if (!last_acc || credits !== 3'd1) begin n_bad++; $display("FAIL simul_net0: got cred %0d want 1", credits); end
        repeat (31) step(1, 4'd10, 0, 0);
        idle(80);
        ret_credits(3);
        if (credits !== 3'd4) begin n_bad++; $display("FAIL simul_full: got %0d want 4", credits); end
        step(0, 4'd0, 1, 0);
        if (err_credit !== 1'b1 || credits !== 3'd4) begin n_bad++; $display("FAIL spurious_ret: got err %b cred %0d want 1/4", err_credit, credits); end
    endtask

    task automatic test_bubbles();
        clear_obs();
        send_frame(4'd11, 10, 3);
        idle(80);
        n_cmp += 2;
        if (obs_cyc.size() != 32) begin n_bad++; $display("FAIL bubble_count: got %0d want 32", obs_cyc.size()); end
        else begin
            if (obs_cyc[10] - obs_cyc[9] != 4 || !obs_last[31]) begin
                n_bad++; $display("FAIL bubble_gap: got gap %0d last %b want 4/1", obs_cyc[10] - obs_cyc[9], obs_last[31]);
            end
        end
        ret_credits(1);
    endtask

    task automatic test_reset_mid();
        repeat (20) step(1, 4'd12, 0, 0);
        step(1, 4'd12, 0, 1);
        n_cmp += 2;
        if (credits !== 3'd4 || busy !== 0 || s_ready !== 1 || err_credit !== 0) begin
            n_bad++; $display("FAIL rstmid_state: got cred %0d busy %b ready %b err %b want 4/0/1/0", credits, busy, s_ready, err_credit);
        end
        clear_obs();
        idle(70);
        if (obs_cyc.size() != 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d beats want 0", obs_cyc.size()); end
    endtask

    task automatic test_random();
        bit v, r;
        for (int i = 0; i < 4000; i++) begin
            v = ($urandom % 10) < 8;
            r = (m_done > 0) && ($urandom % 3 == 0);
            if (r) m_done--;
            step(v, 4'($urandom), r, 0);
        end
        idle(100);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_credit_exhaust();
        test_simul();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ntt_frame_scheduler.md
# ntt_frame_scheduler

Sequencing controller in front of the fully pipelined NTT core, which has fixed latency and no flow control. It admits polynomial frames of BEATS_PER_FRAME beats from an upstream valid/ready stream and gates each frame on downstream buffer credits. It tracks every beat through the core's latency and regenerates frame-aligned valid, first, last and tag markers on the core output. The core datapath is untouched; the block issues only control and sideband signals.

## Interface
- BEATS_PER_FRAME, 32: beats per polynomial (N / coefficients per beat); power of two.
- PIPE_LATENCY, 64: core latency in cycles, from `core_in_en` beat to matching output beat; must be ≥ 1.
- MAX_INFLIGHT, 4: downstream frame buffer slots, which is also the credit count; power of two.
- TAG_WIDTH, 4: frame tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  upstream beat ready.
- s_tag  in  TAG_WIDTH  frame tag, sampled on the first beat only.
- core_in_en  out  1  beat enters core this cycle (= s_valid & s_ready, combinational).
- core_in_first  out  1  the entering beat is beat 0 of its frame.
- core_beat_idx  out  $clog2(BEATS_PER_FRAME)  index of the entering beat.
- m_valid  out  1  core output beat is valid.
- m_first  out  1  m_valid beat is beat 0 of its frame.
- m_last  out  1  m_valid beat is the final beat of its frame.
- m_tag  out  TAG_WIDTH  tag of the frame currently on the output.
- credit_return  in  1  downstream has freed one frame slot (pulse).
- credits  out  $clog2(MAX_INFLIGHT)+1  credits currently available.
- busy  out  1  a frame is being admitted or any beat is in flight.
- err_credit  out  1  sticky: credit_return arrived while credits == MAX_INFLIGHT.

## Operation
- **FSM states.** IDLE and STREAM.
- **IDLE.**
  - s_ready = (credits != 0).
  - An accepted beat is beat 0:
    - capture s_tag into the tag FIFO;
    - decrement credits;
    - set beat_cnt to 1;
    - go to STREAM.
- **STREAM.**
  - s_ready = 1.
  - Each accepted beat increments beat_cnt.
  - Accepting beat BEATS_PER_FRAME-1 returns the FSM to IDLE with beat_cnt = 0.
  - No credit is consumed mid-frame.
- **Bubbles.** s_valid may drop inside a frame. core_in_en is then 0, the core processes garbage, and that slot is marked invalid.
- **Delay line.** A PIPE_LATENCY-deep shift register carries {en, first, last} per cycle and produces m_valid, m_first and m_last.
- **Tag FIFO.**
  - Depth MAX_INFLIGHT.
  - Pushed on admission, popped on m_valid & m_last.
  - m_tag = FIFO head.
  - It cannot overflow because pushes are bounded by credits.
- **Credits.**
  - Admit only: −1. credit_return only: +1.
  - Admit and credit_return in the same cycle: net 0.
  - credit_return with credits == MAX_INFLIGHT: ignored, and err_credit is set.
- **busy** = (state == STREAM) | (any delay-line en bit set).

## Timing
- Reset values:
  - state = IDLE, beat_cnt = 0, credits = MAX_INFLIGHT;
  - delay line and tag FIFO cleared;
  - s_ready = 1 on the first cycle after reset;
  - m_valid, m_first, m_last, busy, err_credit = 0; m_tag = 0.
- A beat accepted at cycle t appears as m_valid at cycle t + PIPE_LATENCY. Bubbles are preserved exactly.
- Back-to-back frames with credits available take zero idle cycles. Beat 0 of frame k+1 is accepted the cycle after the last beat of frame k.
- A credit_return at cycle t is usable for admission at t+1. It is not usable combinationally at t.
- Reset mid-frame or with beats in flight drops all frames and restores full credits. Core outputs after reset are ignored because the delay line is clear.

## Structure
- **Package `ntt_pkg`.**
  - Scheduler state enum.
  - Defaults for BEATS_PER_FRAME, PIPE_LATENCY, MAX_INFLIGHT, TAG_WIDTH.
  - Beat-index width function.
- **Sub-module `ntt_tag_fifo`.** Synchronous FIFO with parameterised depth and width, push/pop/head and count, no output register.
- **Delay line.** Inline shift register.

## Test plan
- **Single frame.** Tag 5, 32 contiguous beats at t0.
  - m_valid runs t0+64 … t0+95.
  - m_first at t0+64, m_last at t0+95.
  - m_tag = 5 throughout.
- **Back-to-back.** Tags 1, 2, 3 sent continuously.
  - 96 consecutive m_valid beats.
  - m_tag switches 1→2 at beat 32 and 2→3 at beat 64.
  - credits goes 4→1.
- **Credit exhaustion.** Four frames, no credit_return.
  - s_ready = 0 in IDLE.
  - One credit_return pulse re-enables s_ready on the next cycle.
- **Simultaneous admit and credit_return.** Both in the same cycle with credits = 1.
  - credits stays 1.
  - A spurious return at credits = 4 sets err_credit and leaves credits at 4.
- **Bubbles.** s_valid low on beats 10–12.
  - Output has an identical 3-cycle gap.
  - m_last still arrives on the 32nd valid beat.
- **Reset mid-operation.** rst asserted during beat 20.
  - Next cycle: credits = 4, busy = 0, state IDLE.
  - No m_valid for the remaining latency window.
